// File: rtl/go_pkg.sv
// Shared Go-board types and constants for move_commit and the player input blocks.
package go_pkg;

    localparam int         BOARD_N   = 9;
    localparam logic [7:0] PASS_MOVE = 8'hFF;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_CHECK = 2'b10
    } state_t;

    function automatic cell_t other_colour(input cell_t c);
        return (c == BLACK) ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/move_history_buf.sv
// Circular buffer of accepted moves; read index 0 is the newest entry and
// slots never written since the last clear read as 8'h00.
module move_history_buf
    import go_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [7:0]    i_push_move,
    input  logic [AW-1:0] i_rd_idx,
    output logic [7:0]    o_rd_move
);

    logic [7:0]       r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    w_rd_addr;

    always_ff @(posedge clk_in) begin
        if (i_clear) begin
            r_valid <= '0;
            r_wptr  <= '0;
        end else if (i_push) begin
            r_valid[r_wptr] <= 1'b1;
            r_wptr          <= r_wptr + AW'(1);
        end
    end

    // Entry storage carries no reset; the valid bits mask stale contents.
    always_ff @(posedge clk_in) begin
        if (i_push && !i_clear) begin
            r_mem[r_wptr] <= i_push_move;
        end
    end

    assign w_rd_addr = r_wptr - AW'(1) - i_rd_idx;
    assign o_rd_move = r_valid[w_rd_addr] ? r_mem[w_rd_addr] : 8'h00;

endmodule

// File: rtl/move_commit.sv
// Validates and commits player moves to the shared 9x9 board, tracks turn and
// end of game. Optional move history is enabled with the MOVE_HISTORY_EN macro.
module move_commit
    import go_pkg::*;
#(
    parameter int  BOARD_N    = go_pkg::BOARD_N,
    parameter int  HIST_DEPTH = 16,
    localparam int HIST_AW    = $clog2(HIST_DEPTH)
) (
    input  logic                                  clk_in,
    input  logic                                  reset,
    input  logic                                  new_game,
    input  logic                                  move_ready,
    input  logic [7:0]                            move_in,
    output logic [BOARD_N-1:0][BOARD_N-1:0][1:0]  board,
    output logic [1:0]                            turn,
    output logic                                  busy,
    output logic                                  commit_pulse,
    output logic                                  reject_pulse,
    output logic                                  game_over,
    output logic [7:0]                            move_count,
    output logic [7:0]                            last_move,
    input  logic [HIST_AW-1:0]                    hist_rd_idx,
    output logic [7:0]                            hist_rd_move
);

    localparam logic [3:0] N_LIM = 4'(BOARD_N);

    state_t                                r_state;
    logic [7:0]                            r_move;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0]  r_board;
    cell_t                                 r_turn;
    logic                                  r_pass_flag;
    logic                                  r_game_over;
    logic                                  r_commit;
    logic                                  r_reject;
    logic [7:0]                            r_count;
    logic [7:0]                            r_last;

    logic [3:0] w_row;
    logic [3:0] w_col;
    logic       w_is_pass;
    logic       w_in_range;
    logic [1:0] w_cell;
    logic       w_accept;
    logic       w_clear;

    assign w_clear = reset || new_game;

    always_comb begin
        w_row      = r_move[7:4];
        w_col      = r_move[3:0];
        w_is_pass  = (r_move == PASS_MOVE);
        w_in_range = (w_row < N_LIM) && (w_col < N_LIM);
        w_cell     = EMPTY;
        if (w_in_range) begin
            w_cell = r_board[w_row][w_col];
        end
        w_accept   = !r_game_over && (w_is_pass || (w_in_range && w_cell == EMPTY));
    end

    always_ff @(posedge clk_in) begin
        if (w_clear) begin
            r_state     <= ST_IDLE;
            r_board     <= '0;
            r_turn      <= BLACK;
            r_pass_flag <= 1'b0;
            r_game_over <= 1'b0;
            r_commit    <= 1'b0;
            r_reject    <= 1'b0;
            r_count     <= 8'h00;
            r_last      <= 8'h00;
        end else begin
            r_commit <= 1'b0;
            r_reject <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (move_ready) begin
                        r_move  <= move_in;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Any move_ready seen here is dropped, not queued.
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        r_commit <= 1'b1;
                        r_turn   <= other_colour(r_turn);
                        r_last   <= r_move;
                        if (r_count != 8'hFF) begin
                            r_count <= r_count + 8'h01;
                        end
                        if (w_is_pass) begin
                            if (r_pass_flag) begin
                                r_game_over <= 1'b1;
                            end else begin
                                r_pass_flag <= 1'b1;
                            end
                        end else begin
                            r_board[w_row][w_col] <= r_turn;
                            r_pass_flag           <= 1'b0;
                        end
                    end else begin
                        r_reject <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign board        = r_board;
    assign turn         = r_turn;
    assign busy         = (r_state == ST_CHECK);
    assign commit_pulse = r_commit;
    assign reject_pulse = r_reject;
    assign game_over    = r_game_over;
    assign move_count   = r_count;
    assign last_move    = r_last;

`ifdef MOVE_HISTORY_EN
    logic w_hist_push;

    assign w_hist_push = (r_state == ST_CHECK) && w_accept && !w_clear;

    move_history_buf #(
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk_in      (clk_in),
        .i_clear     (w_clear),
        .i_push      (w_hist_push),
        .i_push_move (r_move),
        .i_rd_idx    (hist_rd_idx),
        .o_rd_move   (hist_rd_move)
    );
`else
    logic w_unused_hist_idx;

    assign w_unused_hist_idx = ^hist_rd_idx;
    assign hist_rd_move      = 8'h00;
`endif

endmodule

// File: tb/tb_move_commit.sv
// Self-checking bench for move_commit: directed vector table, multi-cycle
// corner sequences and randomized moves against a behavioural game model.
module tb_move_commit;

    localparam int BN = 9;
    localparam int HD = 16;

    logic                        clk_in = 1'b0;
    logic                        reset;
    logic                        new_game;
    logic                        move_ready;
    logic [7:0]                  move_in;
    logic [BN-1:0][BN-1:0][1:0]  board;
    logic [1:0]                  turn;
    logic                        busy;
    logic                        commit_pulse;
    logic                        reject_pulse;
    logic                        game_over;
    logic [7:0]                  move_count;
    logic [7:0]                  last_move;
    logic [3:0]                  hist_rd_idx;
    logic [7:0]                  hist_rd_move;

    move_commit #(.BOARD_N(BN), .HIST_DEPTH(HD)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .new_game     (new_game),
        .move_ready   (move_ready),
        .move_in      (move_in),
        .board        (board),
        .turn         (turn),
        .busy         (busy),
        .commit_pulse (commit_pulse),
        .reject_pulse (reject_pulse),
        .game_over    (game_over),
        .move_count   (move_count),
        .last_move    (last_move),
        .hist_rd_idx  (hist_rd_idx),
        .hist_rd_move (hist_rd_move)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural game model
    int         m_board [BN][BN];
    int         m_turn;
    bit         m_pass;
    bit         m_over;
    int         m_count;
    logic [7:0] m_last;
    logic [7:0] m_hist [$];

    typedef struct {
        logic [7:0] mv;
        bit         ng;
        bit         exp_commit;
        logic [1:0] exp_turn;
        logic [7:0] exp_count;
        bit         exp_over;
        logic [7:0] probe;
        logic [1:0] exp_cell;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < BN; r++)
            for (int c = 0; c < BN; c++)
                m_board[r][c] = 0;
        m_turn  = 1;
        m_pass  = 1'b0;
        m_over  = 1'b0;
        m_count = 0;
        m_last  = 8'h00;
        m_hist.delete();
    endtask

    function automatic bit model_legal(input logic [7:0] mv);
        int r;
        int c;
        if (m_over) return 1'b0;
        if (mv == 8'hFF) return 1'b1;
        r = int'(mv[7:4]);
        c = int'(mv[3:0]);
        if (r >= BN || c >= BN) return 1'b0;
        return m_board[r][c] == 0;
    endfunction

    task automatic model_apply(input logic [7:0] mv);
        if (model_legal(mv)) begin
            m_count = (m_count < 255) ? m_count + 1 : 255;
            m_last  = mv;
            m_hist.push_front(mv);
            if (m_hist.size() > HD) void'(m_hist.pop_back());
            if (mv == 8'hFF) begin
                if (m_pass) m_over = 1'b1;
                else        m_pass = 1'b1;
            end else begin
                m_board[int'(mv[7:4])][int'(mv[3:0])] = m_turn;
                m_pass = 1'b0;
            end
            m_turn = 3 - m_turn;
        end
    endtask

    task automatic check_board(input string name);
        int bad = 0;
        for (int r = 0; r < BN; r++)
            for (int c = 0; c < BN; c++)
                if (int'(board[r][c]) != m_board[r][c]) bad++;
        chk(name, bad, 0);
    endtask

    task automatic check_model(input string tag);
        int         idx;
        logic [7:0] exp_h;
        idx = $urandom_range(0, HD - 1);
        hist_rd_idx = 4'(idx);
        #1;
        exp_h = 8'h00;
`ifdef MOVE_HISTORY_EN
        if (idx < m_hist.size()) exp_h = m_hist[idx];
`endif
        chk({tag, "_turn"}, turn, m_turn);
        chk({tag, "_count"}, move_count, m_count);
        chk({tag, "_last"}, last_move, m_last);
        chk({tag, "_over"}, game_over, m_over);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hist"}, hist_rd_move, exp_h);
        check_board({tag, "_board_cells_wrong"});
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(posedge clk_in); #1;
        new_game = 1'b0;
        model_clear();
    endtask

    // Strobe one move in IDLE; return pulses observed two cycles later.
    task automatic send(input logic [7:0] mv, output bit c, output bit r);
        move_in    = mv;
        move_ready = 1'b1;
        @(posedge clk_in); #1;
        move_ready = 1'b0;
        chk("busy_in_check", busy, 1);
        @(posedge clk_in); #1;
        c = commit_pulse;
        r = reject_pulse;
    endtask

    task automatic send_checked(input logic [7:0] mv, input string tag);
        bit exp_ok;
        bit c;
        bit r;
        exp_ok = model_legal(mv);
        send(mv, c, r);
        chk({tag, "_commit"}, c, exp_ok);
        chk({tag, "_reject"}, r, !exp_ok);
        model_apply(mv);
        check_model(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c;
        bit r;
        logic [7:0] mv;
        int sel;

        vecs[0]  = '{8'h34, 0, 1, 2'b10, 8'd1, 0, 8'h34, 2'b01};
        vecs[1]  = '{8'h34, 0, 0, 2'b10, 8'd1, 0, 8'h34, 2'b01};
        vecs[2]  = '{8'h90, 0, 0, 2'b10, 8'd1, 0, 8'h34, 2'b01};
        vecs[3]  = '{8'h09, 0, 0, 2'b10, 8'd1, 0, 8'h34, 2'b01};
        vecs[4]  = '{8'h88, 0, 1, 2'b01, 8'd2, 0, 8'h88, 2'b10};
        vecs[5]  = '{8'hFF, 0, 1, 2'b10, 8'd3, 0, 8'h88, 2'b10};
        vecs[6]  = '{8'hFF, 0, 1, 2'b01, 8'd4, 1, 8'h00, 2'b00};
        vecs[7]  = '{8'h00, 0, 0, 2'b01, 8'd4, 1, 8'h00, 2'b00};
        vecs[8]  = '{8'hFF, 1, 1, 2'b10, 8'd1, 0, 8'h34, 2'b00};
        vecs[9]  = '{8'h11, 0, 1, 2'b01, 8'd2, 0, 8'h11, 2'b10};
        vecs[10] = '{8'hFF, 0, 1, 2'b10, 8'd3, 0, 8'h11, 2'b10};
        vecs[11] = '{8'hFF, 0, 1, 2'b01, 8'd4, 1, 8'h11, 2'b10};

        reset       = 1'b1;
        new_game    = 1'b0;
        move_ready  = 1'b0;
        move_in     = 8'h00;
        hist_rd_idx = 4'd0;
        model_clear();
        repeat (3) @(posedge clk_in);
        #1;
        reset = 1'b0;
        chk("rst_commit", commit_pulse, 0);
        chk("rst_reject", reject_pulse, 0);
        check_model("rst");

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].ng) do_new_game();
            send(vecs[i].mv, c, r);
            model_apply(vecs[i].mv);
            chk($sformatf("vec%0d_commit", i), c, vecs[i].exp_commit);
            chk($sformatf("vec%0d_reject", i), r, !vecs[i].exp_commit);
            chk($sformatf("vec%0d_turn", i), turn, vecs[i].exp_turn);
            chk($sformatf("vec%0d_count", i), move_count, vecs[i].exp_count);
            chk($sformatf("vec%0d_over", i), game_over, vecs[i].exp_over);
            chk($sformatf("vec%0d_probe", i),
                board[vecs[i].probe[7:4]][vecs[i].probe[3:0]], vecs[i].exp_cell);
            check_board($sformatf("vec%0d_board_cells_wrong", i));
        end

        // move_ready while in CHECK is dropped
        do_new_game();
        move_in    = 8'h22;
        move_ready = 1'b1;
        @(posedge clk_in); #1;
        chk("drop_busy", busy, 1);
        move_in = 8'h33;
        @(posedge clk_in); #1;
        move_ready = 1'b0;
        chk("drop_first_commit", commit_pulse, 1);
        model_apply(8'h22);
        @(posedge clk_in); #1;
        chk("drop_no_commit", commit_pulse, 0);
        chk("drop_no_reject", reject_pulse, 0);
        check_model("drop");

        // new_game wins over a simultaneous move_ready
        new_game   = 1'b1;
        move_ready = 1'b1;
        move_in    = 8'h44;
        @(posedge clk_in); #1;
        new_game   = 1'b0;
        move_ready = 1'b0;
        model_clear();
        chk("ngmv_busy", busy, 0);
        @(posedge clk_in); #1;
        chk("ngmv_commit", commit_pulse, 0);
        chk("ngmv_reject", reject_pulse, 0);
        check_model("ngmv");

        // Reset in CHECK discards the latched move
        send_checked(8'h12, "pre_rst");
        move_in    = 8'h55;
        move_ready = 1'b1;
        @(posedge clk_in); #1;
        move_ready = 1'b0;
        reset      = 1'b1;
        @(posedge clk_in); #1;
        reset = 1'b0;
        model_clear();
        chk("midrst_busy", busy, 0);
        @(posedge clk_in); #1;
        chk("midrst_commit", commit_pulse, 0);
        check_model("midrst");

        // Randomized play against the model
        do_new_game();
        for (int n = 0; n < 300; n++) begin
            if (m_over || $urandom_range(0, 60) == 0) begin
                do_new_game();
                check_model("rnd_ng");
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      mv = 8'hFF;
            else if (sel == 1) mv = 8'($urandom);
            else               mv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            send_checked(mv, "rnd");
        end

`ifdef MOVE_HISTORY_EN
        // 17 accepted stones: newest is the 17th, index 15 is the 2nd
        do_new_game();
        for (int k = 0; k < 17; k++) begin
            send_checked({4'(k / BN), 4'(k % BN)}, "hist");
        end
        hist_rd_idx = 4'd0;
        #1;
        chk("hist_idx0", hist_rd_move, 8'h17);
        hist_rd_idx = 4'd15;
        #1;
        chk("hist_idx15", hist_rd_move, 8'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
